// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel compositor.
package vga_pkg;

  typedef enum logic [1:0] {
    BG_SOLID   = 2'd0,
    BG_CHECKER = 2'd1,
    BG_BARS    = 2'd2
  } bg_mode_t;

  localparam logic [1:0] CFG_BG       = 2'd0;
  localparam logic [1:0] CFG_BG_ALT   = 2'd1;
  localparam logic [1:0] CFG_MODE     = 2'd2;
  localparam logic [1:0] CFG_LAYER_EN = 2'd3;

  // One bit per channel {r,g,b}; each bit is replicated across the channel width.
  localparam logic [2:0] RESET_BG_RGB     = 3'b100;
  localparam logic [2:0] RESET_BG_ALT_RGB = 3'b000;

  localparam int PIX_LATENCY = 2;

endpackage

// File: rtl/layer_priority_sel.sv
// Combinational sprite priority select: lowest set index wins, plus an overlap flag.
module layer_priority_sel #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 4
) (
  input  logic [NUM_LAYERS-1:0]           active,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] rgb,
  output logic                            hit,
  output logic [3*COLOR_W-1:0]            win_rgb,
  output logic                            multi
);

  localparam int RGB_W = 3*COLOR_W;
  localparam logic [NUM_LAYERS-1:0] ONE = NUM_LAYERS'(1);

  // Scan from the top down so the lowest active index is written last.
  always_comb begin
    hit     = 1'b0;
    win_rgb = '0;
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      if (active[i]) begin
        hit     = 1'b1;
        win_rgb = rgb[i*RGB_W +: RGB_W];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(active & (active - ONE));

endmodule

// File: rtl/vga_compositor.sv
// Sprite/background pixel compositor with frame-synchronous config and collision reporting.
module vga_compositor
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 4
) (
  input  logic                            clk_25mhz,
  input  logic                            reset_n,
  input  logic [9:0]                      hcount,
  input  logic [9:0]                      vcount,
  input  logic                            display_en_in,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic                            frame_start_in,
  input  logic [NUM_LAYERS-1:0]           layer_active,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic                            cfg_we,
  input  logic [1:0]                      cfg_addr,
  input  logic [3*COLOR_W-1:0]            cfg_data,
  output logic [COLOR_W-1:0]              vga_r,
  output logic [COLOR_W-1:0]              vga_g,
  output logic [COLOR_W-1:0]              vga_b,
  output logic                            vga_hsync,
  output logic                            vga_vsync,
  output logic [NUM_LAYERS-1:0]           collision_mask,
  output logic                            collision_valid
);

  localparam int RGB_W = 3*COLOR_W;
  localparam logic [RGB_W-1:0] BG_RST = {{COLOR_W{RESET_BG_RGB[2]}},
                                         {COLOR_W{RESET_BG_RGB[1]}},
                                         {COLOR_W{RESET_BG_RGB[0]}}};
  localparam logic [RGB_W-1:0] ALT_RST = {{COLOR_W{RESET_BG_ALT_RGB[2]}},
                                          {COLOR_W{RESET_BG_ALT_RGB[1]}},
                                          {COLOR_W{RESET_BG_ALT_RGB[0]}}};

  logic [RGB_W-1:0]      bg_pend, bg_act, alt_pend, alt_act;
  bg_mode_t              mode_pend, mode_act, mode_wr;
  logic [NUM_LAYERS-1:0] en_pend, en_act;

  logic [NUM_LAYERS-1:0] masked;
  logic                  sel_hit, sel_multi;
  logic [RGB_W-1:0]      sel_rgb, bg_pix;

  logic                  s1_hit, s1_de, s1_hs, s1_vs;
  logic [RGB_W-1:0]      s1_win, s1_bg, s2_rgb;
  logic                  s2_hs, s2_vs;
  logic [NUM_LAYERS-1:0] coll_acc, coll_now;

  // Mode code 3 has no meaning and is folded into SOLID at write time.
  always_comb begin
    case (cfg_data[1:0])
      2'd1:    mode_wr = BG_CHECKER;
      2'd2:    mode_wr = BG_BARS;
      default: mode_wr = BG_SOLID;
    endcase
  end

  // Commit reads the pending copy's old value, so a same-cycle write waits a frame.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      bg_pend   <= BG_RST;
      alt_pend  <= ALT_RST;
      mode_pend <= BG_SOLID;
      en_pend   <= '1;
      bg_act    <= BG_RST;
      alt_act   <= ALT_RST;
      mode_act  <= BG_SOLID;
      en_act    <= '1;
    end else begin
      if (frame_start_in) begin
        bg_act   <= bg_pend;
        alt_act  <= alt_pend;
        mode_act <= mode_pend;
        en_act   <= en_pend;
      end
      if (cfg_we) begin
        case (cfg_addr)
          CFG_BG:       bg_pend   <= cfg_data;
          CFG_BG_ALT:   alt_pend  <= cfg_data;
          CFG_MODE:     mode_pend <= mode_wr;
          CFG_LAYER_EN: en_pend   <= cfg_data[NUM_LAYERS-1:0];
          default:      ;
        endcase
      end
    end
  end

  assign masked = layer_active & en_act;

  layer_priority_sel #(
    .NUM_LAYERS (NUM_LAYERS),
    .COLOR_W    (COLOR_W)
  ) u_sel (
    .active  (masked),
    .rgb     (layer_rgb),
    .hit     (sel_hit),
    .win_rgb (sel_rgb),
    .multi   (sel_multi)
  );

  always_comb begin
    bg_pix = bg_act;
    case (mode_act)
      BG_CHECKER: if (hcount[4] ^ vcount[4]) bg_pix = alt_act;
      BG_BARS:    bg_pix = {{COLOR_W{hcount[9]}}, {COLOR_W{hcount[8]}}, {COLOR_W{hcount[7]}}};
      default:    ;
    endcase
  end

  // Two-stage pixel pipeline; syncs idle high through both stages.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      s1_hit <= 1'b0;
      s1_win <= '0;
      s1_bg  <= '0;
      s1_de  <= 1'b0;
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
      s2_rgb <= '0;
      s2_hs  <= 1'b1;
      s2_vs  <= 1'b1;
    end else begin
      s1_hit <= sel_hit;
      s1_win <= sel_rgb;
      s1_bg  <= bg_pix;
      s1_de  <= display_en_in;
      s1_hs  <= hsync_in;
      s1_vs  <= vsync_in;
      s2_rgb <= !s1_de ? '0 : (s1_hit ? s1_win : s1_bg);
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
    end
  end

  assign vga_r     = s2_rgb[3*COLOR_W-1:2*COLOR_W];
  assign vga_g     = s2_rgb[2*COLOR_W-1:COLOR_W];
  assign vga_b     = s2_rgb[COLOR_W-1:0];
  assign vga_hsync = s2_hs;
  assign vga_vsync = s2_vs;

  assign coll_now = (display_en_in && sel_multi) ? masked : '0;

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      coll_acc        <= '0;
      collision_mask  <= '0;
      collision_valid <= 1'b0;
    end else if (frame_start_in) begin
      collision_mask  <= coll_acc | coll_now;
      coll_acc        <= '0;
      collision_valid <= 1'b1;
    end else begin
      coll_acc        <= coll_acc | coll_now;
      collision_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_compositor.sv
// Scoreboard bench for vga_compositor: a behavioural model predicts each pixel and sync.
module tb_vga_compositor;

  localparam int NL = 4;
  localparam int CW = 4;
  localparam int RW = 3*CW;
  localparam int W  = RW + 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [9:0]      hcount, vcount;
  logic            display_en_in, hsync_in, vsync_in, frame_start_in;
  logic [NL-1:0]   layer_active;
  logic [NL*RW-1:0] layer_rgb;
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [RW-1:0]   cfg_data;
  logic [CW-1:0]   vga_r, vga_g, vga_b;
  logic            vga_hsync, vga_vsync;
  logic [NL-1:0]   collision_mask;
  logic            collision_valid;

  vga_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW)) dut (
    .clk_25mhz       (clk),
    .reset_n         (reset_n),
    .hcount          (hcount),
    .vcount          (vcount),
    .display_en_in   (display_en_in),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .frame_start_in  (frame_start_in),
    .layer_active    (layer_active),
    .layer_rgb       (layer_rgb),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .vga_r           (vga_r),
    .vga_g           (vga_g),
    .vga_b           (vga_b),
    .vga_hsync       (vga_hsync),
    .vga_vsync       (vga_vsync),
    .collision_mask  (collision_mask),
    .collision_valid (collision_valid)
  );

  // Clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  // Next-cycle stimulus, applied by cycle()
  logic [9:0]       n_hc, n_vc;
  logic             n_de, n_hs, n_vs, n_fs, n_we;
  logic [NL-1:0]    n_act;
  logic [NL*RW-1:0] n_rgb;
  logic [1:0]       n_addr;
  logic [RW-1:0]    n_data;

  // Model state
  logic [RW-1:0] p_bg, p_alt, m_bg, m_alt;
  logic [1:0]    p_mode, m_mode;
  logic [NL-1:0] p_en, m_en, m_acc, exp_cm;
  logic          exp_cv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] bg_model(input logic [9:0] hc, input logic [9:0] vc);
    logic [RW-1:0] c;
    c = m_bg;
    if (m_mode == 2'd1 && (hc[4] ^ vc[4])) c = m_alt;
    if (m_mode == 2'd2) c = {{CW{hc[9]}}, {CW{hc[8]}}, {CW{hc[7]}}};
    return c;
  endfunction

  task automatic model_reset();
    p_bg = 12'hF00; m_bg = 12'hF00;
    p_alt = '0; m_alt = '0;
    p_mode = 2'd0; m_mode = 2'd0;
    p_en = '1; m_en = '1;
    m_acc = '0; exp_cm = '0; exp_cv = 1'b0;
    exp_q.delete();
    exp_q.push_back({{RW{1'b0}}, 2'b11});
    exp_q.push_back({{RW{1'b0}}, 2'b11});
  endtask

  task automatic drive_idle();
    hcount = '0; vcount = '0;
    display_en_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; frame_start_in = 1'b0;
    layer_active = '0; layer_rgb = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
  endtask

  // One pixel: check what leaves the pipeline, then apply and predict the next input.
  task automatic cycle();
    logic [W-1:0]  e;
    logic [RW-1:0] exp_rgb;
    logic [NL-1:0] m;
    logic          found;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e[W-1:2]));
      check("hsync", 32'(vga_hsync), 32'(e[1]));
      check("vsync", 32'(vga_vsync), 32'(e[0]));
    end
    check("coll_valid", 32'(collision_valid), 32'(exp_cv));
    check("coll_mask", 32'(collision_mask), 32'(exp_cm));

    hcount = n_hc; vcount = n_vc;
    display_en_in = n_de; hsync_in = n_hs; vsync_in = n_vs; frame_start_in = n_fs;
    layer_active = n_act; layer_rgb = n_rgb;
    cfg_we = n_we; cfg_addr = n_addr; cfg_data = n_data;

    m = n_act & m_en;
    exp_rgb = '0;
    if (n_de) begin
      exp_rgb = bg_model(n_hc, n_vc);
      found = 1'b0;
      for (int i = 0; i < NL; i++) begin
        if (m[i] && !found) begin
          exp_rgb = n_rgb[i*RW +: RW];
          found = 1'b1;
        end
      end
    end
    exp_q.push_back({exp_rgb, n_hs, n_vs});

    if (n_de && $countones(m) >= 2) m_acc = m_acc | m;
    exp_cv = n_fs;
    if (n_fs) begin
      exp_cm = m_acc; m_acc = '0;
      m_bg = p_bg; m_alt = p_alt; m_mode = p_mode; m_en = p_en;
    end
    if (n_we) begin
      case (n_addr)
        2'd0: p_bg = n_data;
        2'd1: p_alt = n_data;
        2'd2: p_mode = (n_data[1:0] == 2'd3) ? 2'd0 : n_data[1:0];
        default: p_en = n_data[NL-1:0];
      endcase
    end
    n_we = 1'b0;
    n_fs = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      n_hc = (n_hc == 10'd799) ? 10'd0 : n_hc + 10'd1;
      n_hs = ($urandom_range(0, 3) != 0);
      n_vs = ($urandom_range(0, 7) != 0);
      cycle();
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [RW-1:0] data);
    n_we = 1'b1; n_addr = addr; n_data = data;
    run(1);
  endtask

  task automatic frame();
    n_fs = 1'b1;
    run(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rst_hsync", 32'(vga_hsync), 32'd1);
    check("rst_vsync", 32'(vga_vsync), 32'd1);
    check("rst_cmask", 32'(collision_mask), 32'd0);
    check("rst_cvalid", 32'(collision_valid), 32'd0);
    drive_idle();
    model_reset();
    n_hc = '0; n_vc = '0; n_de = 1'b0; n_hs = 1'b1; n_vs = 1'b1;
    n_fs = 1'b0; n_we = 1'b0; n_act = '0; n_addr = '0; n_data = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive_idle();
    n_rgb = '0;
    repeat (3) @(posedge clk);
    do_reset();

    // Reset defaults: red background while displaying, black otherwise
    n_de = 1'b1; run(6);
    n_de = 1'b0; run(4);
    n_de = 1'b1;

    // Priority between layers 1 and 2, collision reported at next frame
    n_rgb = {12'h123, 12'h00F, 12'h0F0, 12'h456};
    n_act = 4'b0110; run(6);
    n_act = 4'b0000; run(2);
    frame(); run(3);

    // Layer enable written mid-frame applies from the next frame
    wr(2'd3, 12'h00D);
    n_act = 4'b0010; run(4);
    frame(); run(4);
    n_act = 4'b0000;

    // Write on the commit cycle lands one frame later
    n_we = 1'b1; n_addr = 2'd0; n_data = 12'h00F;
    frame(); run(4);
    frame(); run(4);

    // Checkerboard
    wr(2'd1, 12'hFFF); wr(2'd2, 12'h001); frame();
    n_hc = 10'd16; n_vc = 10'd0;  cycle();
    n_hc = 10'd16; n_vc = 10'd16; cycle();
    n_hc = 10'd0;  n_vc = 10'd16; cycle();
    n_hc = 10'd0;  n_vc = 10'd0;  cycle();
    run(40);

    // Colour bars and sync alignment
    wr(2'd2, 12'h002); frame();
    n_hc = 10'd384; cycle();
    n_hc = 10'd383; run(300);

    // Random traffic with config writes and frame strobes
    for (int k = 0; k < 400; k++) begin
      n_act = NL'($urandom_range(0, (1 << NL) - 1));
      for (int i = 0; i < NL; i++) n_rgb[i*RW +: RW] = RW'($urandom_range(0, 4095));
      n_de = ($urandom_range(0, 4) != 0);
      n_vc = 10'($urandom_range(0, 524));
      if ($urandom_range(0, 9) == 0) begin
        n_we = 1'b1; n_addr = 2'($urandom_range(0, 3)); n_data = RW'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 29) == 0) n_fs = 1'b1;
      run(1);
    end

    // Mid-line reset then recovery
    n_act = 4'b0011; run(3);
    do_reset();
    n_de = 1'b1; n_act = '0; run(4);
    frame(); run(4);
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_compositor.md
# vga_compositor

Parametrised pixel compositor between the VGA timing generator, the per-object sprite renderers and the R-2R DAC pins. It merges `NUM_LAYERS` prioritised sprite layers over a configurable background (solid, checkerboard or colour bars) and forces black during blanking. Background and layer-enable settings come through a register-write port and apply only at frame boundaries, so frames never tear. Sprite overlaps are recorded per frame, e.g. for ball/paddle hits, and reported as a collision mask.

## Interface
- `NUM_LAYERS`, 4: sprite layer count, 1..8. Must satisfy `NUM_LAYERS <= 3*COLOR_W`.
- `COLOR_W`, 4: bits per colour channel.
- `clk_25mhz`  in  1  pixel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `hcount`, `vcount`  in  10 each  pixel coordinates from the timing generator.
- `display_en_in`, `hsync_in`, `vsync_in`, `frame_start_in`  in  1 each  timing strobes, same cycle as `hcount`/`vcount`.
- `layer_active`  in  NUM_LAYERS  per-layer pixel-hit flags.
- `layer_rgb`  in  NUM_LAYERS*3*COLOR_W  layer i colour at `[i*3*COLOR_W +: 3*COLOR_W]`, packed {r,g,b}.
- `cfg_we`  in  1  register write strobe, single cycle, always accepted.
- `cfg_addr`  in  2  register select.
- `cfg_data`  in  3*COLOR_W  write data.
- `vga_r`, `vga_g`, `vga_b`  out  COLOR_W each  pixel colour to the DAC.
- `vga_hsync`, `vga_vsync`  out  1 each  sync outputs, delay-matched to the colour outputs.
- `collision_mask`  out  NUM_LAYERS  layers involved in any overlap during the previous frame.
- `collision_valid`  out  1  one-cycle pulse when `collision_mask` updates.

## Operation
- **Registers.** Each register has a pending copy and an active copy.
  - 0: `bg_color` {r,g,b}.
  - 1: `bg_alt_color` {r,g,b}.
  - 2: `bg_mode` in bits [1:0]. 0 = SOLID, 1 = CHECKER, 2 = BARS, 3 = treated as SOLID.
  - 3: `layer_en` in bits [NUM_LAYERS-1:0]. Upper bits are ignored.
- **Register reset values.** `bg_color` = full red (all-ones r, g=0, b=0). `bg_alt_color` = 0. `bg_mode` = SOLID. `layer_en` = all ones.
- **Writes and commit.**
  - `cfg_we` writes the pending copy.
  - When `frame_start_in` is high, all pending copies move to the active copies. The commit uses the pending values as they were *before* any write in that same cycle, so a simultaneous write lands in the next frame.
  - Composition reads active copies only.
- **Layer selection.** The winner is the lowest index i with `layer_active[i] & layer_en[i]`. Layer 0 has the highest priority.
- **Background.**
  - SOLID: `bg_color`.
  - CHECKER: `hcount[4]^vcount[4]` selects `bg_alt_color` when 1, otherwise `bg_color`.
  - BARS: b2 = `hcount[9]`, b1 = `hcount[8]`, b0 = `hcount[7]`. r = {COLOR_W{b2}}, g = {COLOR_W{b1}}, b = {COLOR_W{b0}}.
- **Output colour.** If delayed `display_en` = 0, the output is 0. Otherwise it is the winning layer colour, or the background if no layer wins.
- **Collision detection.**
  - On a cycle with `display_en_in` = 1, collect the enabled active layers (`layer_active & layer_en`).
  - If two or more are set, OR them into an accumulator.
  - On `frame_start_in`: `collision_mask` <= accumulator including the current cycle. The accumulator clears. `collision_valid` pulses.
- **Reset mid-frame.** All pipeline state, registers and accumulators return to reset values immediately. Output resumes correctly from the next `frame_start_in`, with no requirement before that.

## Timing
- **Pixel path latency: 2 cycles.**
  - Inputs at cycle N appear on the `vga_*` colour outputs at N+2.
  - `hsync_in`, `vsync_in` and `display_en_in` pass through a matching 2-stage delay.
  - Stage 1 registers the winner flag, winner colour, background colour and `display_en`.
  - Stage 2 registers the final mux.
- **Config commit.** `frame_start_in` at cycle N makes the new active values affect pixels whose inputs arrive at N+1 or later, which appear at the output from N+3.
- **Collision.** `frame_start_in` at N gives `collision_mask` and `collision_valid` = 1 at N+1, and `collision_valid` = 0 at N+2.
- **Reset values.**
  - `vga_r`/`vga_g`/`vga_b` = 0.
  - `vga_hsync` = `vga_vsync` = 1 (inactive, negative-polarity 640x480), including both sync delay stages.
  - `collision_mask` = 0, `collision_valid` = 0.

## Structure
- **Shared package `vga_pkg`:**
  - `bg_mode_t` enum (SOLID, CHECKER, BARS).
  - `CFG_BG`, `CFG_BG_ALT`, `CFG_MODE`, `CFG_LAYER_EN` address constants.
  - Reset colour constants.
  - `PIX_LATENCY` = 2.
- **Sub-module `layer_priority_sel`:** combinational lowest-index winner select. Outputs a hit flag, the winning colour and a ≥2-overlap flag.
- Stage registers, config shadows and the collision accumulator stay in `vga_compositor`.

## Test plan
- **Reset defaults.** Stimulus: `display_en_in` = 1, no layers active. Required: from N+2 the output is (F,0,0). With `display_en_in` = 0 the output is (0,0,0).
- **Priority.** Stimulus: layers 1 and 2 active with colours (0,F,0) and (0,0,F). Required: output (0,F,0) after 2 cycles, and `collision_mask` = 4'b0110 with a `collision_valid` pulse 1 cycle after the next `frame_start_in`.
- **Layer enable.** Stimulus: write `layer_en` = 4'b1101 mid-frame, then raise layer 1 alone. Required: layer 1 still shows until `frame_start_in`, then the background shows.
- **Simultaneous write and commit.** Stimulus: write `bg_color` = (0,0,F) on the same cycle as `frame_start_in`. Required: red persists for that frame and blue appears after the following `frame_start_in`.
- **CHECKER mode.** Stimulus: `bg_alt_color` = (F,F,F). Required: `hcount` = 16, `vcount` = 0 gives (F,F,F); `hcount` = 16, `vcount` = 16 gives `bg_color`.
- **BARS mode and sync alignment.** Stimulus: BARS mode. Required: `hcount` = 384 gives (0,F,F), and `vga_hsync` edges trail `hsync_in` by exactly 2 cycles. Assert `reset_n` mid-line: outputs are 0 and syncs are 1 immediately.
